// File: rtl/player_input_decoder.sv
// player_input_decoder
//   Turns the raw USB HID keycode into debounced, one-hot movement requests,
//   a facing-direction flag and a single-frame jump strobe. Everything runs on
//   frame_clk, so there is one update per video frame.
//   Optional build macro: JUMP_REPEAT_EN. When it is defined, holding space
//   re-fires after every cooldown. When it is undefined (the default), space
//   must be released between jumps.
module player_input_decoder #(
  parameter int unsigned HOLD_FRAMES   = 2,
  parameter int unsigned JUMP_COOLDOWN = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       move_left,
  output logic       move_right,
  output logic       climb_up,
  output logic       climb_down,
  output logic       jump_pulse,
  output logic       facing_left,
  output logic       jump_busy
);

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_LEFT  = 3'd1,
    CLS_RIGHT = 3'd2,
    CLS_UP    = 3'd3,
    CLS_DOWN  = 3'd4,
    CLS_JUMP  = 3'd5
  } key_class_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_WAIT_REL = 2'd3
  } jump_state_e;

  // A cooldown of 0 behaves like a cooldown of 1.
  localparam int unsigned CD_EFF   = (JUMP_COOLDOWN == 0) ? 1 : JUMP_COOLDOWN;
  localparam logic [7:0]  HOLD_LIM = 8'(HOLD_FRAMES);
  localparam logic [7:0]  CD_LAST  = 8'(CD_EFF - 1);

  key_class_e  dec_cls_s;
  key_class_e  cls_q;
  logic [7:0]  stab_cnt;
  logic [7:0]  stab_nxt_s;
  logic        held_s;
  logic        jump_held_s;
  jump_state_e state_r;
  jump_state_e state_nxt_s;
  logic [7:0]  cd_cnt;
  logic [7:0]  cd_nxt_s;

  // Map the keycode to a movement class. Unlisted codes are treated as no key.
  always_comb begin
    dec_cls_s = CLS_NONE;
    case (keycode)
      8'h04, 8'h50: dec_cls_s = CLS_LEFT;
      8'h07, 8'h4F: dec_cls_s = CLS_RIGHT;
      8'h1A, 8'h52: dec_cls_s = CLS_UP;
      8'h16, 8'h51: dec_cls_s = CLS_DOWN;
      8'h2C:        dec_cls_s = CLS_JUMP;
      default:      dec_cls_s = CLS_NONE;
    endcase
  end

  // Stability counter: restart on a class change, otherwise count up to HOLD_FRAMES.
  always_comb begin
    stab_nxt_s = stab_cnt;
    if (dec_cls_s != cls_q) begin
      stab_nxt_s = 8'd0;
    end else if (stab_cnt >= HOLD_LIM) begin
      stab_nxt_s = HOLD_LIM;
    end else begin
      stab_nxt_s = stab_cnt + 8'd1;
    end
  end

  // Debounce registers: sampled class and its stability count.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cls_q    <= CLS_NONE;
      stab_cnt <= 8'd0;
    end else begin
      cls_q    <= dec_cls_s;
      stab_cnt <= stab_nxt_s;
    end
  end

  assign held_s      = (stab_cnt == HOLD_LIM);
  assign jump_held_s = (cls_q == CLS_JUMP) && held_s;

  // The commands decode a single registered class, so at most one of them is high.
  assign move_left  = (cls_q == CLS_LEFT)  && held_s;
  assign move_right = (cls_q == CLS_RIGHT) && held_s;
  assign climb_up   = (cls_q == CLS_UP)    && held_s;
  assign climb_down = (cls_q == CLS_DOWN)  && held_s;

  // Facing remembers the last debounced horizontal request.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      facing_left <= 1'b0;
    end else if (move_left) begin
      facing_left <= 1'b1;
    end else if (move_right) begin
      facing_left <= 1'b0;
    end else begin
      facing_left <= facing_left;
    end
  end

  // Jump next-state logic. cd_cnt is held at zero while idle and counts the
  // frames elapsed since the pulse, so FIRE plus COOLDOWN span JUMP_COOLDOWN frames.
  always_comb begin
    state_nxt_s = state_r;
    cd_nxt_s    = cd_cnt;
    case (state_r)
      ST_IDLE: begin
        cd_nxt_s = 8'd0;
        if (jump_held_s) begin
          state_nxt_s = ST_FIRE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FIRE: begin
        cd_nxt_s    = cd_cnt + 8'd1;
        state_nxt_s = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cd_cnt >= CD_LAST) begin
          cd_nxt_s = 8'd0;
`ifdef JUMP_REPEAT_EN
          state_nxt_s = ST_IDLE;
`else
          state_nxt_s = ST_WAIT_REL;
`endif
        end else begin
          cd_nxt_s    = cd_cnt + 8'd1;
          state_nxt_s = ST_COOLDOWN;
        end
      end
      ST_WAIT_REL: begin
        cd_nxt_s = 8'd0;
        if (!jump_held_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_REL;
        end
      end
      default: begin
        cd_nxt_s    = 8'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Jump state and cooldown counter registers. Reset abandons any jump in progress.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cd_cnt  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cd_cnt  <= cd_nxt_s;
    end
  end

  assign jump_pulse = (state_r == ST_FIRE);
  assign jump_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_player_input_decoder.sv
// Self-checking bench for player_input_decoder. A reference model built on
// run lengths and "frames since last pulse" predicts every output each frame.
module tb_player_input_decoder;

  localparam int HOLD = 2;
  localparam int JC   = 30;
  localparam int CL   = (JC < 2) ? 2 : JC;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       move_left, move_right, climb_up, climb_down;
  logic       jump_pulse, facing_left, jump_busy;

  int checks;
  int errors;

  // model state
  int m_cls;
  int m_run;
  int m_edge;
  int m_last_pulse;
  bit m_rel_seen;
  bit m_face;
  int pulse_count;

  player_input_decoder #(.HOLD_FRAMES(HOLD), .JUMP_COOLDOWN(JC)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .move_left  (move_left),
    .move_right (move_right),
    .climb_up   (climb_up),
    .climb_down (climb_down),
    .jump_pulse (jump_pulse),
    .facing_left(facing_left),
    .jump_busy  (jump_busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic int key_class(input logic [7:0] kc);
    if (kc == 8'h04 || kc == 8'h50) return 1;
    if (kc == 8'h07 || kc == 8'h4F) return 2;
    if (kc == 8'h1A || kc == 8'h52) return 3;
    if (kc == 8'h16 || kc == 8'h51) return 4;
    if (kc == 8'h2C) return 5;
    return 0;
  endfunction

  function automatic bit m_idle();
    if (m_last_pulse < 0) return 1'b1;
`ifdef JUMP_REPEAT_EN
    return (m_edge - m_last_pulse) >= CL;
`else
    return ((m_edge - m_last_pulse) >= CL + 1) && m_rel_seen;
`endif
  endfunction

  function automatic bit m_held();
    return (m_run - 1) >= HOLD;
  endfunction

  function automatic logic [6:0] m_expect();
    logic [6:0] v;
    v[6] = (m_cls == 1) && m_held();
    v[5] = (m_cls == 2) && m_held();
    v[4] = (m_cls == 3) && m_held();
    v[3] = (m_cls == 4) && m_held();
    v[2] = (m_last_pulse >= 0) && (m_last_pulse == m_edge);
    v[1] = m_face;
    v[0] = !m_idle();
    return v;
  endfunction

  task automatic model_reset();
    m_cls        = 0;
    m_run        = 1;
    m_last_pulse = -1;
    m_rel_seen   = 1'b0;
    m_face       = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] obs;
    logic [6:0] exp_v;
    obs   = {move_left, move_right, climb_up, climb_down, jump_pulse, facing_left, jump_busy};
    exp_v = m_expect();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s frame %0d: observed %b expected %b (L R U D pulse face busy)", tag, m_edge, obs, exp_v);
    end
  endtask

  task automatic step(input logic [7:0] kc, input string tag);
    int  d;
    bit  held_b, ml_b, mr_b, jh_b, idle_b;
    keycode = kc;
    d       = key_class(kc);
    held_b  = m_held();
    ml_b    = (m_cls == 1) && held_b;
    mr_b    = (m_cls == 2) && held_b;
    jh_b    = (m_cls == 5) && held_b;
    idle_b  = m_idle();
    @(posedge frame_clk);
    m_edge++;
    if (ml_b) m_face = 1'b1;
    else if (mr_b) m_face = 1'b0;
    if (m_last_pulse >= 0 && (m_edge - m_last_pulse) >= CL + 1 && !jh_b) m_rel_seen = 1'b1;
    if (idle_b && jh_b) begin
      m_last_pulse = m_edge;
      m_rel_seen   = 1'b0;
    end
    if (d == m_cls) m_run++;
    else begin
      m_cls = d;
      m_run = 1;
    end
    #1;
    if (jump_pulse === 1'b1) pulse_count++;
    check_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  logic [7:0] codes [13];

  initial begin
    int n;
    int exp_pulses;
    codes = '{8'h04, 8'h50, 8'h07, 8'h4F, 8'h1A, 8'h52, 8'h16, 8'h51,
              8'h2C, 8'h2C, 8'h00, 8'h99, 8'h2C};
    checks      = 0;
    errors      = 0;
    m_edge      = 0;
    pulse_count = 0;
    keycode     = 8'h00;
    Reset       = 1'b1;
    model_reset();
    #2;
    check_outputs("reset_state");
    @(negedge frame_clk);
    Reset = 1'b0;

    // left held, then switch to right mid-hold
    for (int i = 0; i < 5; i++) step(8'h04, "left_hold");
    for (int i = 0; i < 5; i++) step(8'h4F, "right_hold");

    // toggling up/none never settles
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 8'h52 : 8'h00, "up_toggle");
      checks++;
      assert (dut.stab_cnt === 8'd0) else begin
        errors++;
        $error("FAIL stab_toggle: observed %0d expected 0", dut.stab_cnt);
      end
    end

    // every other mapped key, then an unmapped code
    for (int i = 0; i < 4; i++) step(8'h1A, "up_w");
    for (int i = 0; i < 4; i++) step(8'h16, "down_s");
    for (int i = 0; i < 4; i++) step(8'h51, "down_arrow");
    for (int i = 0; i < 4; i++) step(8'h50, "left_arrow");
    for (int i = 0; i < 4; i++) step(8'h99, "unmapped");
    for (int i = 0; i < 4; i++) step(8'h07, "right_d");
    for (int i = 0; i < 4; i++) step(8'h00, "release");

    // space held for 100 frames from a fresh reset
    pulse_reset("reset_before_space");
    pulse_count = 0;
    for (int i = 0; i < 100; i++) step(8'h2C, "space_hold");
`ifdef JUMP_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    checks++;
    assert (pulse_count === exp_pulses) else begin
      errors++;
      $error("FAIL space_pulse_count: observed %0d expected %0d", pulse_count, exp_pulses);
    end
    for (int i = 0; i < 5; i++) step(8'h00, "space_release");

    // reset in the middle of a cooldown with space still down
    for (int i = 0; i < 10; i++) step(8'h2C, "space_pre_reset");
    pulse_reset("reset_in_cooldown");
    for (int i = 0; i < 8; i++) step(8'h2C, "space_post_reset");

    // randomized holds over all key classes, with occasional resets
    for (int r = 0; r < 80; r++) begin
      n = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0) n = $urandom_range(30, 45);
      for (int i = 0; i < n; i++) step(codes[$urandom_range(0, 12)] & ((i == 0 || $urandom_range(0, 5) != 0) ? 8'hFF : 8'hFF), "random");
      if ($urandom_range(0, 24) == 0) pulse_reset("random_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
